// File: rtl/addr_sequencer.sv
// addr_sequencer: emits a decimated sequence of addresses from start_addr to
// stop_addr (inclusive, wrapping modulo 2^ADDR_SIZE), one-shot or looping.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   en                - rising edge starts a sequence, falling edge aborts it
//   loop              - 1 = restart at start_addr after stop_addr, 0 = one-shot
//   decimate          - idle cycles between emitted addresses
//   start_addr        - first address emitted
//   stop_addr         - last address emitted
//   addr, addr_valid  - emitted address and its one-cycle strobe
//   wrap              - one-cycle pulse with the final strobe of a looping pass
//   finish            - level, high once a one-shot sequence has completed
//   busy              - level, high while the sequencer is running
module addr_sequencer #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DEC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 loop,
    input  logic [DEC_WIDTH-1:0] decimate,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [ADDR_SIZE-1:0] stop_addr,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 addr_valid,
    output logic                 wrap,
    output logic                 finish,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   en_r_q, en_r_d;
    logic                   loop_l_q, loop_l_d;
    logic [DEC_WIDTH-1:0]   dec_l_q, dec_l_d;
    logic [ADDR_SIZE-1:0]   start_l_q, start_l_d;
    logic [ADDR_SIZE-1:0]   stop_l_q, stop_l_d;
    logic [ADDR_SIZE-1:0]   counter_q, counter_d;
    logic [DEC_WIDTH-1:0]   dec_cnt_q, dec_cnt_d;
    // Emit decision stage; the output registers follow one cycle later.
    logic                   emit_p_q, emit_p_d;
    logic [ADDR_SIZE-1:0]   addr_p_q, addr_p_d;
    logic                   wrap_p_q, wrap_p_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic                   addr_valid_q, addr_valid_d;
    logic                   wrap_q, wrap_d;
    logic                   finish_q, finish_d;
    logic                   busy_q, busy_d;

    logic rise_c;
    logic fall_c;

    assign rise_c = en & ~en_r_q;
    assign fall_c = ~en & en_r_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            en_r_q       <= 1'b0;
            loop_l_q     <= 1'b0;
            dec_l_q      <= '0;
            start_l_q    <= '0;
            stop_l_q     <= '0;
            counter_q    <= '0;
            dec_cnt_q    <= '0;
            emit_p_q     <= 1'b0;
            addr_p_q     <= '0;
            wrap_p_q     <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            finish_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_r_q       <= en_r_d;
            loop_l_q     <= loop_l_d;
            dec_l_q      <= dec_l_d;
            start_l_q    <= start_l_d;
            stop_l_q     <= stop_l_d;
            counter_q    <= counter_d;
            dec_cnt_q    <= dec_cnt_d;
            emit_p_q     <= emit_p_d;
            addr_p_q     <= addr_p_d;
            wrap_p_q     <= wrap_p_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            wrap_q       <= wrap_d;
            finish_q     <= finish_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        en_r_d       = en;
        loop_l_d     = loop_l_q;
        dec_l_d      = dec_l_q;
        start_l_d    = start_l_q;
        stop_l_d     = stop_l_q;
        counter_d    = counter_q;
        dec_cnt_d    = dec_cnt_q;
        emit_p_d     = 1'b0;
        addr_p_d     = addr_p_q;
        wrap_p_d     = 1'b0;
        addr_d       = emit_p_q ? addr_p_q : addr_q;
        addr_valid_d = emit_p_q;
        wrap_d       = wrap_p_q;
        // finish rises once the final strobe has left the output stage.
        finish_d     = finish_q | ((state_q == DONE) & ~emit_p_q);

        if (fall_c) begin
            // Abort wins over any emit decided or pending this cycle.
            state_d      = IDLE;
            counter_d    = '0;
            dec_cnt_d    = '0;
            addr_d       = '0;
            addr_valid_d = 1'b0;
            wrap_d       = 1'b0;
            finish_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        loop_l_d  = loop;
                        dec_l_d   = decimate;
                        start_l_d = start_addr;
                        stop_l_d  = stop_addr;
                        counter_d = start_addr;
                        dec_cnt_d = '0;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    // Equality test, so D = all-ones never overflows dec_cnt.
                    if (dec_cnt_q == dec_l_q) begin
                        dec_cnt_d = '0;
                        emit_p_d  = 1'b1;
                        addr_p_d  = counter_q;
                        if (counter_q == stop_l_q) begin
                            if (loop_l_q) begin
                                counter_d = start_l_q;
                                wrap_p_d  = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            counter_d = counter_q + ADDR_SIZE'(1);
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q + DEC_WIDTH'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN);
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign wrap       = wrap_q;
    assign finish     = finish_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed self-checking bench for addr_sequencer (ADDR_SIZE=8, DEC_WIDTH=32).
module tb_addr_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        loop;
    logic [31:0] decimate;
    logic [7:0]  start_addr;
    logic [7:0]  stop_addr;
    logic [7:0]  addr;
    logic        addr_valid;
    logic        wrap;
    logic        finish;
    logic        busy;

    int checks = 0;
    int errors = 0;

    addr_sequencer #(.ADDR_SIZE(8), .DEC_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .loop       (loop),
        .decimate   (decimate),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .addr       (addr),
        .addr_valid (addr_valid),
        .wrap       (wrap),
        .finish     (finish),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".addr"},   32'(addr), 32'd0);
        check({tag, ".valid"},  32'(addr_valid), 32'd0);
        check({tag, ".wrap"},   32'(wrap), 32'd0);
        check({tag, ".finish"}, 32'(finish), 32'd0);
        check({tag, ".busy"},   32'(busy), 32'd0);
    endtask

    // Checks n cycles after the rise edge. Strobe k lands d+2+k*(d+1) edges
    // after the rise; its address is start+(k mod L), L = pass length.
    task automatic run_seq(input string tag, input int n, input int d,
                           input logic [7:0] s, input logic [7:0] e, input bit lp);
        int       len;
        int       last;
        int       k;
        bit       exp_v;
        logic [7:0] exp_a;
        len  = int'(8'(e - s)) + 1;
        last = d + 2 + (len - 1) * (d + 1);
        for (int i = 1; i <= n; i++) begin
            step();
            exp_v = 1'b0;
            k     = 0;
            if (i >= d + 2 && ((i - (d + 2)) % (d + 1)) == 0) begin
                k = (i - (d + 2)) / (d + 1);
                if (lp || k < len) exp_v = 1'b1;
            end
            check($sformatf("%s.valid[%0d]", tag, i), 32'(addr_valid), 32'(exp_v));
            if (exp_v) begin
                exp_a = 8'(s + 8'(k % len));
                check($sformatf("%s.addr[%0d]", tag, i), 32'(addr), 32'(exp_a));
                check($sformatf("%s.wrap[%0d]", tag, i), 32'(wrap),
                      32'(lp && ((k % len) == len - 1)));
            end else begin
                check($sformatf("%s.wrap[%0d]", tag, i), 32'(wrap), 32'd0);
            end
            check($sformatf("%s.finish[%0d]", tag, i), 32'(finish), 32'(!lp && i > last));
            check($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'(lp || i < last - 1));
        end
    endtask

    task automatic start_seq(input string tag, input int d, input logic [7:0] s,
                             input logic [7:0] e, input bit lp);
        decimate   = 32'(d);
        start_addr = s;
        stop_addr  = e;
        loop       = lp;
        en         = 1'b1;
        step();
        check({tag, ".busy0"},  32'(busy), 32'd1);
        check({tag, ".valid0"}, 32'(addr_valid), 32'd0);
    endtask

    task automatic stop_seq(input string tag);
        en = 1'b0;
        step();
        check_idle_zero({tag, ".abort"});
        step();
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        loop       = 1'b0;
        decimate   = 32'd0;
        start_addr = 8'd0;
        stop_addr  = 8'd0;
        #12;
        check_idle_zero("reset");
        rst = 1'b0;
        step();
        check_idle_zero("idle");

        // One-shot D=0, 3..6; finish then held while en stays high.
        start_seq("oneshot", 0, 8'd3, 8'd6, 1'b0);
        run_seq("oneshot", 8, 0, 8'd3, 8'd6, 1'b0);
        check("oneshot.hold_addr", 32'(addr), 32'd6);
        stop_seq("oneshot");

        // Decimation D=2, 0..2.
        start_seq("decim", 2, 8'd0, 8'd2, 1'b0);
        run_seq("decim", 12, 2, 8'd0, 8'd2, 1'b0);
        stop_seq("decim");

        // Loop through the all-ones address.
        start_seq("loopwrap", 0, 8'd254, 8'd1, 1'b1);
        run_seq("loopwrap", 10, 0, 8'd254, 8'd1, 1'b1);
        stop_seq("loopwrap");

        // start == stop in loop mode: one address per pass, wrap every strobe.
        start_seq("single", 1, 8'd5, 8'd5, 1'b1);
        run_seq("single", 7, 1, 8'd5, 8'd5, 1'b1);
        stop_seq("single");

        // Abort in the gap after the third strobe.
        start_seq("abort", 3, 8'd10, 8'd20, 1'b0);
        run_seq("abort", 14, 3, 8'd10, 8'd20, 1'b0);
        en = 1'b0;
        step();
        check_idle_zero("abort.fall");
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("abort.quiet[%0d]", i), 32'(addr_valid), 32'd0);
        end

        // Restart, then change the config mid-run: latched values must hold.
        start_seq("iso", 3, 8'd10, 8'd20, 1'b0);
        start_addr = 8'd100;
        stop_addr  = 8'd101;
        decimate   = 32'd0;
        run_seq("iso", 10, 3, 8'd10, 8'd20, 1'b0);

        // Async reset between edges with en still high.
        #2;
        rst = 1'b1;
        #1;
        check_idle_zero("asyncrst");
        @(negedge clk);
        rst = 1'b0;
        // en high at release: the first edge sees a rise with the new config.
        step();
        check("rstrise.busy", 32'(busy), 32'd1);
        run_seq("rstrise", 5, 0, 8'd100, 8'd101, 1'b0);
        stop_seq("rstrise");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 8, giving the address width in bits.
REQ-002 The block SHALL have parameter DEC_WIDTH, default 32, giving the decimation field width in bits.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all logic is on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port en SHALL be an input, 1 bit wide: run enable; its rising edge starts a sequence and its falling edge aborts it.
REQ-006 Port loop SHALL be an input, 1 bit wide: 1 = repeat the sequence, 0 = one-shot.
REQ-007 Port decimate SHALL be an input, DEC_WIDTH bits wide: D, the number of idle cycles between emitted addresses.
REQ-008 Port start_addr SHALL be an input, ADDR_SIZE bits wide: the first address emitted.
REQ-009 Port stop_addr SHALL be an input, ADDR_SIZE bits wide: the last address emitted, inclusive.
REQ-010 Port addr SHALL be an output, ADDR_SIZE bits wide: the emitted address, registered.
REQ-011 Port addr_valid SHALL be an output, 1 bit wide: a one-cycle strobe qualifying addr.
REQ-012 Port wrap SHALL be an output, 1 bit wide: a one-cycle pulse marking a loop restart.
REQ-013 Port finish SHALL be an output, 1 bit wide: level, high once a one-shot sequence completes.
REQ-014 Port busy SHALL be an output, 1 bit wide: level, high while in RUN.

Function
REQ-015 en SHALL be registered to en_r. Edge detection:
- rise = en & ~en_r
- fall = ~en & en_r
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 On rise in IDLE, the block SHALL:
- latch loop, decimate, start_addr and stop_addr into shadow registers;
- set counter = start_addr and dec_counter = 0;
- enter RUN.
REQ-018 Input changes outside a rise SHALL be ignored until the next rise.
REQ-019 In RUN, on each clock:
- if dec_counter == D_latched: set dec_counter = 0 and emit counter (addr <= counter, addr_valid <= 1 on the next cycle);
- otherwise: increment dec_counter and set addr_valid <= 0.
REQ-020 Timing with decimation D SHALL be:
- first addr_valid high exactly D+2 rising edges after the edge sampling rise;
- subsequent strobes every D+1 cycles;
- D = 0 gives one strobe per cycle.
REQ-021 On a non-final emit, counter SHALL increment modulo 2^ADDR_SIZE.
REQ-022 stop_addr < start_addr SHALL be legal: the sequence wraps through the all-ones address to 0 and continues until it reaches stop_addr.
REQ-023 stop_addr == start_addr SHALL emit a single address per pass.
REQ-024 On the emit of counter == stop_addr with loop_latched = 1, the block SHALL:
- set counter = start_addr_latched;
- pulse wrap high for one cycle, coincident with that final addr_valid;
- remain in RUN.
REQ-025 On the emit of counter == stop_addr with loop_latched = 0, the block SHALL:
- enter DONE;
- raise finish on the cycle after the final addr_valid.
REQ-026 In DONE, the block SHALL:
- hold addr, finish = 1, addr_valid = 0, busy = 0;
- ignore en held high.
REQ-027 On fall in any state, the block SHALL:
- return to IDLE on the next edge;
- clear counter, dec_counter, addr, addr_valid, wrap and finish to 0.
REQ-028 Falling edge SHALL take priority over any emit in the same cycle; an emit pending on that cycle is discarded.
REQ-029 A new sequence SHALL require en to return low (fall) before a fresh rise; a rise SHALL be acted on only in IDLE.
REQ-030 busy SHALL equal (state == RUN), registered.
REQ-031 The full dec_counter comparison SHALL use DEC_WIDTH bits; D = 2^DEC_WIDTH-1 SHALL be legal without overflow.

Reset
REQ-032 rst asserted SHALL immediately force:
- state IDLE;
- addr = 0, addr_valid = 0, wrap = 0, finish = 0, busy = 0;
- en_r = 0, counter = 0, dec_counter = 0;
- all shadow registers = 0.
REQ-033 If en is high when rst releases, the first clock SHALL detect a rise, since en_r = 0 after reset.
REQ-034 rst mid-RUN SHALL abort the sequence with no further addr_valid strobes.

Verification
REQ-035 One-shot, D=0, start=3, stop=6, loop=0:
- addr_valid high 4 consecutive cycles with addr 3,4,5,6;
- finish high the next cycle and held.
REQ-036 Decimation, D=2, start=0, stop=2:
- strobes spaced exactly 3 cycles apart;
- first strobe 4 edges after the rise.
REQ-037 Loop, ADDR_SIZE=8, start=254, stop=1, D=0, loop=1:
- addr sequence 254,255,0,1,254,...;
- wrap high coincident with each addr 1;
- finish never asserts.
REQ-038 Abort:
- drop en during the 3rd strobe's decimation gap: no further strobes;
- addr, finish and busy return to 0 within 1 cycle;
- re-raise en to restart from start_addr.
REQ-039 Config isolation: change start_addr, stop_addr and decimate mid-RUN; the sequence SHALL continue unchanged with the latched values.
REQ-040 Async reset: assert rst between clock edges mid-RUN; all outputs SHALL read 0 before the next edge.
